// File: rtl/ws2812_pkg.sv
// Shared types and constants for the WS2812 frame scheduler and its encoder.
package ws2812_pkg;

   localparam int PIXEL_W = 24;

   // GRB byte order on the wire: green first
   localparam int G_MSB = 23;
   localparam int R_MSB = 15;
   localparam int B_MSB = 7;

   localparam int DEFAULT_LATCH_CYCLES = 5000;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      PIX_OUT,
      DRAIN,
      LATCH
   } sched_state_t;

endpackage

// File: rtl/ws2812_frame_sched_if.sv
// Pixel stream between the frame scheduler (master) and the serial bit encoder (slave).
interface ws2812_frame_sched_if;

   logic                           pix_valid;
   logic [ws2812_pkg::PIXEL_W-1:0] pix_data;
   logic                           pix_ready;
   logic                           enc_busy;

   modport master (
      output pix_valid,
      output pix_data,
      input  pix_ready,
      input  enc_busy
   );

   modport slave (
      input  pix_valid,
      input  pix_data,
      output pix_ready,
      output enc_busy
   );

endinterface

// File: rtl/ws2812_latch_timer.sv
// Loadable down-counter with a zero flag; times the WS2812 latch/reset gap.
module ws2812_latch_timer #(
   parameter int TIMER_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [TIMER_W-1:0] load_val,
   input  logic               dec,
   output logic               zero
);

   logic [TIMER_W-1:0] count_q;
   logic [TIMER_W-1:0] count_d;

   // Load wins over decrement; the counter parks at zero instead of wrapping
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - TIMER_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/ws2812_frame_sched.sv
// Owns the shared pixel RAM port and sequences full-strip refresh frames:
// read each pixel, hand it to the encoder, then hold the latch gap.
module ws2812_frame_sched
   import ws2812_pkg::*;
#(
   parameter int ADDR_W       = 11,
   parameter int LATCH_CYCLES = DEFAULT_LATCH_CYCLES,
   parameter int TIMER_W      = 16,
   parameter int AUTO_REFRESH = 0
) (
   input  logic                 clk,
   input  logic                 rst,

   input  logic                 wr_req,
   input  logic [ADDR_W-1:0]    wr_addr,
   input  logic [PIXEL_W-1:0]   wr_data,

   input  logic [19:0]          data_depth,
   input  logic                 refresh_en,
   input  logic                 frame_trig,

   output logic                 ram_en,
   output logic                 ram_we,
   output logic [ADDR_W-1:0]    ram_addr,
   output logic [PIXEL_W-1:0]   ram_wdata,
   input  logic [PIXEL_W-1:0]   ram_rdata,

   ws2812_frame_sched_if.master pix_if,

   output logic                 frame_busy,
   output logic                 frame_done
);

   localparam int          IDX_W     = ADDR_W + 1;
   localparam logic [19:0] MAX_DEPTH = 20'(2 ** ADDR_W);

   sched_state_t       state_q, state_d;
   logic               trig_pending_q, trig_pending_d;
   logic [IDX_W-1:0]   pix_idx_q, pix_idx_d;
   logic [IDX_W-1:0]   depth_q, depth_d;
   logic               pix_valid_q, pix_valid_d;
   logic [PIXEL_W-1:0] pix_data_q, pix_data_d;
   logic               frame_busy_q, frame_busy_d;
   logic               frame_done_q, frame_done_d;

   logic               tmr_load;
   logic               tmr_dec;
   logic               tmr_zero;
   logic               start_ok;
   logic               last_pix;

   ws2812_latch_timer #(
      .TIMER_W (TIMER_W)
   ) u_latch_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (TIMER_W'(LATCH_CYCLES - 1)),
      .dec      (tmr_dec),
      .zero     (tmr_zero)
   );

   assign start_ok = refresh_en && (trig_pending_q || frame_trig || (AUTO_REFRESH != 0))
                     && (data_depth != 20'd0);
   assign last_pix = (pix_idx_q == (depth_q - IDX_W'(1)));

   // Writer traffic always owns the RAM port; the frame read simply waits a cycle
   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (wr_req) begin
         ram_en    = 1'b1;
         ram_we    = 1'b1;
         ram_addr  = wr_addr;
         ram_wdata = wr_data;
      end else if (state_q == RD_REQ) begin
         ram_en   = 1'b1;
         ram_addr = pix_idx_q[ADDR_W-1:0];
      end
   end

   always_comb begin
      state_d        = state_q;
      trig_pending_d = trig_pending_q | frame_trig;
      pix_idx_d      = pix_idx_q;
      depth_d        = depth_q;
      pix_valid_d    = pix_valid_q;
      pix_data_d     = pix_data_q;
      frame_busy_d   = frame_busy_q;
      frame_done_d   = 1'b0;
      tmr_load       = 1'b0;
      tmr_dec        = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_ok) begin
               state_d        = RD_REQ;
               trig_pending_d = 1'b0;
               pix_idx_d      = '0;
               depth_d        = (data_depth > MAX_DEPTH) ? IDX_W'(MAX_DEPTH) : IDX_W'(data_depth);
               frame_busy_d   = 1'b1;
            end
         end
         RD_REQ: begin
            if (!wr_req) begin
               state_d = RD_WAIT;
            end
         end
         RD_WAIT: begin
            pix_data_d  = ram_rdata;
            pix_valid_d = 1'b1;
            state_d     = PIX_OUT;
         end
         PIX_OUT: begin
            if (pix_valid_q && pix_if.pix_ready) begin
               pix_valid_d = 1'b0;
               if (last_pix) begin
                  state_d = DRAIN;
               end else begin
                  pix_idx_d = pix_idx_q + IDX_W'(1);
                  state_d   = RD_REQ;
               end
            end
         end
         DRAIN: begin
            if (!pix_if.enc_busy) begin
               tmr_load = 1'b1;
               state_d  = LATCH;
            end
         end
         LATCH: begin
            if (tmr_zero) begin
               frame_done_d = 1'b1;
               frame_busy_d = 1'b0;
               state_d      = IDLE;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         trig_pending_q <= 1'b0;
         pix_idx_q      <= '0;
         depth_q        <= '0;
         pix_valid_q    <= 1'b0;
         pix_data_q     <= '0;
         frame_busy_q   <= 1'b0;
         frame_done_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         trig_pending_q <= trig_pending_d;
         pix_idx_q      <= pix_idx_d;
         depth_q        <= depth_d;
         pix_valid_q    <= pix_valid_d;
         pix_data_q     <= pix_data_d;
         frame_busy_q   <= frame_busy_d;
         frame_done_q   <= frame_done_d;
      end
   end

   assign pix_if.pix_valid = pix_valid_q;
   assign pix_if.pix_data  = pix_data_q;
   assign frame_busy       = frame_busy_q;
   assign frame_done       = frame_done_q;

endmodule

// File: tb/tb_ws2812_frame_sched.sv
// Directed bench for ws2812_frame_sched with a 1-cycle-latency RAM model.
module tb_ws2812_frame_sched;
   import ws2812_pkg::*;

   localparam int ADDR_W  = 11;
   localparam int LATCH_N = 20;

   logic               clk = 1'b0;
   logic               rst;
   logic               wr_req;
   logic [ADDR_W-1:0]  wr_addr;
   logic [PIXEL_W-1:0] wr_data;
   logic [19:0]        data_depth;
   logic               refresh_en;
   logic               frame_trig;
   logic               ram_en;
   logic               ram_we;
   logic [ADDR_W-1:0]  ram_addr;
   logic [PIXEL_W-1:0] ram_wdata;
   logic [PIXEL_W-1:0] ram_rdata = '0;
   logic               frame_busy;
   logic               frame_done;

   ws2812_frame_sched_if pix_if ();

   ws2812_frame_sched #(
      .ADDR_W       (ADDR_W),
      .LATCH_CYCLES (LATCH_N),
      .TIMER_W      (16),
      .AUTO_REFRESH (0)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_req     (wr_req),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .data_depth (data_depth),
      .refresh_en (refresh_en),
      .frame_trig (frame_trig),
      .ram_en     (ram_en),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata),
      .pix_if     (pix_if.master),
      .frame_busy (frame_busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   logic [PIXEL_W-1:0] mem [0:(1<<ADDR_W)-1];
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else        ram_rdata     <= mem[ram_addr];
      end
   end

   int                 cyc      = 0;
   int                 read_cnt = 0;
   int                 done_cnt = 0;
   logic [PIXEL_W-1:0] hs_data[$];
   int                 hs_cyc[$];
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (ram_en && !ram_we) read_cnt = read_cnt + 1;
      if (frame_done) done_cnt = done_cnt + 1;
      if (!rst && pix_if.pix_valid && pix_if.pix_ready) begin
         hs_data.push_back(pix_if.pix_data);
         hs_cyc.push_back(cyc);
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic [PIXEL_W-1:0] data);
      wr_req  = 1'b1;
      wr_addr = addr;
      wr_data = data;
      tick();
      wr_req  = 1'b0;
   endtask

   task automatic pulseTrig();
      frame_trig = 1'b1;
      tick();
      frame_trig = 1'b0;
   endtask

   task automatic waitDone(input string tag, input int budget);
      int n = 0;
      while (frame_done !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      if (frame_done !== 1'b1) checkOutput(tag, 32'(frame_done), 32'd1);
   endtask

   initial begin
      int n;
      int r0;
      int d0;
      int busy_seen;
      bit stable;

      rst = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
      data_depth = 20'd0; refresh_en = 1'b0; frame_trig = 1'b0;
      pix_if.pix_ready = 1'b1; pix_if.enc_busy = 1'b0;
      tick(); tick();
      checkOutput("rst_pix_valid",  32'(pix_if.pix_valid), 32'd0);
      checkOutput("rst_pix_data",   32'(pix_if.pix_data),  32'd0);
      checkOutput("rst_frame_busy", 32'(frame_busy),       32'd0);
      checkOutput("rst_frame_done", 32'(frame_done),       32'd0);
      checkOutput("rst_ram_en",     32'(ram_en),           32'd0);
      rst = 1'b0;
      tick();

      // Preload through the DUT's write path; writes are combinational to the RAM port
      wr_req = 1'b1; wr_addr = 11'd0; wr_data = 24'h110000;
      #1;
      checkOutput("wr_ram_en",    32'(ram_en),    32'd1);
      checkOutput("wr_ram_we",    32'(ram_we),    32'd1);
      checkOutput("wr_ram_addr",  32'(ram_addr),  32'd0);
      checkOutput("wr_ram_wdata", 32'(ram_wdata), 32'h110000);
      tick(); wr_req = 1'b0;
      applyStimulus(11'd1, 24'h002200);
      applyStimulus(11'd2, 24'h000033);

      // Basic frame, encoder busy until released so the latch gap can be measured
      $display("[TB] basic frame");
      data_depth = 20'd3; refresh_en = 1'b1; pix_if.enc_busy = 1'b1;
      hs_data.delete(); hs_cyc.delete();
      pulseTrig();
      checkOutput("start_busy",    32'(frame_busy), 32'd1);
      checkOutput("rdreq_en",      32'(ram_en),     32'd1);
      checkOutput("rdreq_we",      32'(ram_we),     32'd0);
      checkOutput("rdreq_addr",    32'(ram_addr),   32'd0);
      n = 0;
      while (hs_data.size() < 3 && n < 60) begin tick(); n++; end
      checkOutput("basic_hs_cnt", 32'(hs_data.size()), 32'd3);
      if (hs_data.size() == 3) begin
         checkOutput("basic_px0", 32'(hs_data[0]), 32'h110000);
         checkOutput("basic_px1", 32'(hs_data[1]), 32'h002200);
         checkOutput("basic_px2", 32'(hs_data[2]), 32'h000033);
         checkOutput("basic_rate", 32'(hs_cyc[1] - hs_cyc[0]), 32'd3);
      end
      tick(); tick(); tick();
      checkOutput("drain_busy", 32'(frame_busy), 32'd1);
      checkOutput("drain_done", 32'(frame_done), 32'd0);
      pix_if.enc_busy = 1'b0;
      n = 0;
      while (frame_done !== 1'b1 && n < 200) begin tick(); n++; end
      checkOutput("latch_gap", 32'(n), 32'(LATCH_N + 1));
      checkOutput("done_busy", 32'(frame_busy), 32'd0);
      tick();
      checkOutput("done_pulse", 32'(frame_done), 32'd0);

      // Write to pixel 1 collides with its read request
      $display("[TB] collision");
      hs_data.delete();
      pulseTrig();
      tick(); tick(); tick();
      checkOutput("col_rdreq_addr", 32'(ram_addr), 32'd1);
      wr_req = 1'b1; wr_addr = 11'd1; wr_data = 24'hABCDEF;
      #1;
      checkOutput("col_we",    32'(ram_we),    32'd1);
      checkOutput("col_wdata", 32'(ram_wdata), 32'hABCDEF);
      tick(); wr_req = 1'b0;
      #1;
      checkOutput("col_rd_en",   32'(ram_en),   32'd1);
      checkOutput("col_rd_we",   32'(ram_we),   32'd0);
      checkOutput("col_rd_addr", 32'(ram_addr), 32'd1);
      waitDone("col_timeout", 200);
      checkOutput("col_hs_cnt", 32'(hs_data.size()), 32'd3);
      if (hs_data.size() == 3) begin
         checkOutput("col_px0", 32'(hs_data[0]), 32'h110000);
         checkOutput("col_px1", 32'(hs_data[1]), 32'hABCDEF);
         checkOutput("col_px2", 32'(hs_data[2]), 32'h000033);
      end
      tick();

      // Encoder stalls on pixel 0
      $display("[TB] backpressure");
      hs_data.delete();
      pix_if.pix_ready = 1'b0;
      pulseTrig();
      tick(); tick();
      checkOutput("bp_valid", 32'(pix_if.pix_valid), 32'd1);
      checkOutput("bp_data",  32'(pix_if.pix_data),  32'h110000);
      r0 = read_cnt;
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (pix_if.pix_valid !== 1'b1 || pix_if.pix_data !== 24'h110000) stable = 1'b0;
      end
      checkOutput("bp_stable", 32'(stable), 32'd1);
      checkOutput("bp_no_reads", 32'(read_cnt - r0), 32'd0);
      pix_if.pix_ready = 1'b1;
      waitDone("bp_timeout", 200);
      checkOutput("bp_hs_cnt", 32'(hs_data.size()), 32'd3);
      tick();

      // Zero depth holds the trigger pending until a real depth appears
      $display("[TB] zero depth");
      hs_data.delete();
      data_depth = 20'd0;
      pulseTrig();
      tick(); tick(); tick(); tick();
      checkOutput("zd_busy",   32'(frame_busy), 32'd0);
      checkOutput("zd_ram_en", 32'(ram_en),     32'd0);
      data_depth = 20'd2;
      tick();
      checkOutput("zd_start", 32'(frame_busy), 32'd1);
      waitDone("zd_timeout", 200);
      checkOutput("zd_hs_cnt", 32'(hs_data.size()), 32'd2);
      if (hs_data.size() == 2) checkOutput("zd_px1", 32'(hs_data[1]), 32'hABCDEF);
      tick();

      // Two triggers while busy collapse into one extra frame
      $display("[TB] pending trigger");
      hs_data.delete();
      data_depth = 20'd3;
      d0 = done_cnt;
      pulseTrig();
      tick();
      pulseTrig();
      tick(); tick();
      pulseTrig();
      waitDone("pend_timeout1", 200);
      tick();
      checkOutput("pend_restart", 32'(frame_busy), 32'd1);
      tick();
      waitDone("pend_timeout2", 200);
      busy_seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (frame_busy !== 1'b0) busy_seen++;
      end
      checkOutput("pend_no_third", 32'(busy_seen), 32'd0);
      checkOutput("pend_done_cnt", 32'(done_cnt - d0), 32'd2);
      checkOutput("pend_hs_cnt", 32'(hs_data.size()), 32'd6);

      // Reset while a pixel is being offered
      $display("[TB] reset mid-frame");
      pix_if.pix_ready = 1'b0;
      d0 = done_cnt;
      pulseTrig();
      tick(); tick();
      checkOutput("mr_valid_pre", 32'(pix_if.pix_valid), 32'd1);
      rst = 1'b1;
      tick();
      checkOutput("mr_valid", 32'(pix_if.pix_valid), 32'd0);
      checkOutput("mr_busy",  32'(frame_busy),       32'd0);
      rst = 1'b0;
      pix_if.pix_ready = 1'b1;
      busy_seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (frame_busy !== 1'b0 || ram_en !== 1'b0) busy_seen++;
      end
      checkOutput("mr_idle", 32'(busy_seen), 32'd0);
      checkOutput("mr_no_done", 32'(done_cnt - d0), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ws2812_frame_sched.md
Name: ws2812_frame_sched

Overview:
- Owns the single-port pixel RAM shared by the FIFO-fed pixel writer and the refresh path.
- Sequences full-strip refresh frames: reads pixels 0..depth-1, hands each 24-bit GRB word to the bit encoder over valid/ready, then enforces the WS2812 latch gap.
- Sits between the pixel writer (write/address/rgb_data), the pixel RAM and the serial encoder.

Parameters:
ADDR_W, 11, pixel RAM address width
LATCH_CYCLES, 5000, latch/reset gap in clk cycles after the encoder goes idle (>=50 us at 100 MHz)
TIMER_W, 16, latch timer width; must satisfy LATCH_CYCLES < 2**TIMER_W
AUTO_REFRESH, 0, 1 = restart a frame whenever idle and refresh_en=1

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
wr_req  in  1  1-cycle write strobe from pixel writer (no backpressure)
wr_addr  in  ADDR_W  write address
wr_data  in  24  GRB pixel to write
data_depth  in  20  pixels per frame; sampled at frame start
refresh_en  in  1  enables frame starts
frame_trig  in  1  1-cycle request for one frame
ram_en  out  1  RAM enable
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  24  RAM write data
ram_rdata  in  24  RAM read data, valid 1 cycle after a read enable
pix_valid  out  1  pixel available to encoder
pix_data  out  24  pixel to encoder, GRB [23:16]=G
pix_ready  in  1  encoder accepts pixel
enc_busy  in  1  encoder still shifting bits
frame_busy  out  1  high from frame start until frame_done
frame_done  out  1  1-cycle pulse at end of latch gap

Behaviour:
- Reset values: every registered output is 0 (pix_valid, pix_data, frame_busy, frame_done). State = IDLE, trig_pending = 0, pix_idx = 0.
- Reset mid-frame: IDLE on the next edge and pix_valid = 0. No frame_done is produced.
- RAM port is a combinational mux and writes have absolute priority:
  - wr_req=1 → ram_en=1, ram_we=1, ram_addr=wr_addr, ram_wdata=wr_data, in the same cycle, in any state.
  - Otherwise ram_en=1 and ram_we=0 only in RD_REQ, with ram_addr=pix_idx.
  - Otherwise ram_en=0, ram_we=0, and ram_addr/ram_wdata are 0.
- Writes are never dropped and never delayed. wr_addr >= depth is still written.
- trig_pending: set by frame_trig in any state. Cleared when a frame starts. At most one pending frame.
- IDLE: start a frame when refresh_en && (trig_pending || frame_trig || AUTO_REFRESH) && data_depth != 0.
  - On start: depth_q = min(data_depth, 2**ADDR_W), pix_idx = 0, frame_busy = 1 → RD_REQ.
  - data_depth = 0 keeps the block in IDLE; the trigger stays pending.
- RD_REQ: if wr_req=1, stay (the read is deferred one cycle). Else issue the read → RD_WAIT.
- RD_WAIT: pix_data <= ram_rdata, pix_valid <= 1 → PIX_OUT.
  - A write to the same address in this cycle does not affect the captured data (old data is sent).
- PIX_OUT: hold pix_valid and pix_data stable until pix_valid && pix_ready. On the handshake:
  - pix_valid <= 0.
  - If pix_idx == depth_q-1 → DRAIN. Else pix_idx++ → RD_REQ.
- Minimum cost is 3 cycles per pixel with pix_ready tied high.
- DRAIN: wait for enc_busy == 0, then timer <= LATCH_CYCLES-1 → LATCH.
- LATCH: decrement the timer. At 0: frame_done = 1 for one cycle, frame_busy <= 0 → IDLE.
  - The latch gap is LATCH_CYCLES+1 cycles from enc_busy low to frame_done.
- refresh_en deasserted mid-frame: the current frame completes, including the latch gap. No new start.
- pix_idx is ADDR_W+1 bits wide. No wrap occurs because depth_q <= 2**ADDR_W.

Decomposition:
- Package ws2812_pkg:
  - PIXEL_W = 24
  - G_MSB/R_MSB/B_MSB byte positions
  - state enum: IDLE, RD_REQ, RD_WAIT, PIX_OUT, DRAIN, LATCH
  - default LATCH_CYCLES
- One natural sub-module: ws2812_latch_timer (load/decrement/zero flag, TIMER_W wide). It is reused by the encoder's reset generator.
- The RAM mux stays inline.

Test Plan:
- depth=3, RAM = {0x110000, 0x002200, 0x000033}, pix_ready=1, frame_trig pulse → pix_data sequence 0x110000, 0x002200, 0x000033, one handshake each. frame_done comes LATCH_CYCLES+1 cycles after enc_busy falls.
- Collision: wr_req with addr=1, data=0xABCDEF in the RD_REQ cycle for pixel 1 → ram_we=1 that cycle and the read issues the next cycle. Pixel 1 is sent as 0xABCDEF and no write is lost.
- Backpressure: pix_ready low for 10 cycles on pixel 0 → pix_valid and pix_data are held stable, and no further RAM reads are issued.
- data_depth=0 with frame_trig → stays IDLE, frame_busy=0. Then set depth=2 → the frame starts without a new trigger.
- Two frame_trig pulses during a busy frame → exactly one extra frame, followed by two frame_done pulses in total.
- rst asserted in PIX_OUT → next cycle pix_valid=0, frame_busy=0, state IDLE, no frame_done.
